// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 behind the coherence bus.
// Optional hit/miss counters (stat_hits/stat_misses) are enabled with `define L2_STATS_EN.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module l2_cache #(
    parameter int L2_SETS     = 64,
    parameter int LINE_ADDR_W = `ADDR_BITS - `OFFSET_BITS,
    parameter int LINE_W      = `CACHELINE_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   l2_req_valid,
    output logic                   l2_req_ready,
    input  logic [LINE_ADDR_W-1:0] l2_req_addr,
    input  logic                   l2_req_rw,
    input  logic [LINE_W-1:0]      l2_req_data,
    output logic                   l2_resp_valid,
    output logic [LINE_W-1:0]      l2_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [LINE_ADDR_W-1:0] mem_req_addr,
    output logic                   mem_req_rw,
    output logic [LINE_W-1:0]      mem_req_data,
    input  logic                   mem_resp_valid,
    input  logic [LINE_W-1:0]      mem_resp_data
`ifdef L2_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_misses
`endif
);
    localparam int IDX_W = $clog2(L2_SETS);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_RESP
    } state_t;

    state_t r_state, w_next;

    logic [L2_SETS-1:0] r_valid, r_dirty;
    logic [TAG_W-1:0]   r_tag  [L2_SETS];
    logic [LINE_W-1:0]  r_data [L2_SETS];

    logic [LINE_ADDR_W-1:0] r_addr;
    logic                   r_rw;
    logic [LINE_W-1:0]      r_wdata, r_resp_data;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit, w_victim_dirty;
    logic              w_inst, w_inst_dirty, w_clr_dirty, w_resp_load;
    logic [LINE_W-1:0] w_inst_data, w_resp_src;

    assign w_idx          = r_addr[IDX_W-1:0];
    assign w_tag          = r_addr[LINE_ADDR_W-1:IDX_W];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_inst        = 1'b0;
        w_inst_dirty  = 1'b0;
        w_inst_data   = r_wdata;
        w_clr_dirty   = 1'b0;
        w_resp_load   = 1'b0;
        w_resp_src    = mem_resp_data;
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b0;
        l2_resp_data  = r_resp_data;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_rw    = 1'b0;
        mem_req_data  = '0;
        case (r_state)
            S_IDLE: begin
                l2_req_ready = 1'b1;
                if (l2_req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit && r_rw) begin
                    w_inst = 1'b1; w_inst_dirty = 1'b1; w_next = S_IDLE;
                end else if (w_hit) begin
                    w_resp_load = 1'b1; w_resp_src = r_data[w_idx]; w_next = S_RESP;
                end else if (w_victim_dirty) begin
                    w_next = S_WB_REQ;
                end else if (r_rw) begin
                    // Full-line write needs no fill.
                    w_inst = 1'b1; w_inst_dirty = 1'b1; w_next = S_IDLE;
                end else begin
                    w_next = S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {r_tag[w_idx], w_idx};
                mem_req_data  = r_data[w_idx];
                if (mem_req_ready) begin
                    w_clr_dirty = 1'b1;
                    if (r_rw) begin
                        w_inst = 1'b1; w_inst_dirty = 1'b1; w_next = S_IDLE;
                    end else begin
                        w_next = S_FILL_REQ;
                    end
                end
            end
            S_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_addr;
                if (mem_req_ready) w_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_inst = 1'b1; w_inst_data = mem_resp_data;
                    w_resp_load = 1'b1; w_next = S_RESP;
                end
            end
            S_RESP: begin
                l2_resp_valid = 1'b1;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_wdata     <= '0;
            r_resp_data <= '0;
        end else begin
            if (r_state == S_IDLE && l2_req_valid) begin
                r_addr  <= l2_req_addr;
                r_rw    <= l2_req_rw;
                r_wdata <= l2_req_data;
            end
            if (w_resp_load) r_resp_data <= w_resp_src;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_inst) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= w_inst_dirty;
        end else if (w_clr_dirty) begin
            r_dirty[w_idx] <= 1'b0;
        end
    end

    // Tag/data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (w_inst) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_inst_data;
        end
    end

`ifdef L2_STATS_EN
    logic [31:0] r_hits, r_misses;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && r_hits != 32'hFFFF_FFFF)          r_hits   <= r_hits + 32'd1;
            else if (!w_hit && r_misses != 32'hFFFF_FFFF)  r_misses <= r_misses + 32'd1;
        end
    end
    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
`endif
endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: directed bus/memory traffic, expected
// responses and memory requests queued, checked by a decoupled monitor.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module tb_l2_cache;
    localparam int LAW = `ADDR_BITS - `OFFSET_BITS;
    localparam int LW  = `CACHELINE_BITS;
    localparam logic [LW-1:0] PA = {(LW/32){32'hA5A5_A5A5}};
    localparam logic [LW-1:0] P1 = {(LW/32){32'h1111_1111}};
    localparam logic [LW-1:0] P2 = {(LW/32){32'h2222_2222}};
    localparam logic [LW-1:0] P3 = {(LW/32){32'h3333_3333}};
    localparam logic [LW-1:0] P4 = {(LW/32){32'h4444_4444}};

    typedef struct {
        logic [LAW-1:0] addr;
        logic           rw;
        logic [LW-1:0]  data;
    } mreq_t;

    logic           clk = 1'b0, reset = 1'b1;
    logic           l2_req_valid = 1'b0, l2_req_rw = 1'b0;
    logic [LAW-1:0] l2_req_addr = '0;
    logic [LW-1:0]  l2_req_data = '0;
    logic           l2_req_ready, l2_resp_valid;
    logic [LW-1:0]  l2_resp_data;
    logic           mem_req_valid, mem_req_rw;
    logic           mem_req_ready = 1'b1;
    logic [LAW-1:0] mem_req_addr;
    logic [LW-1:0]  mem_req_data;
    logic           mem_resp_valid = 1'b0;
    logic [LW-1:0]  mem_resp_data = '0;
`ifdef L2_STATS_EN
    logic [31:0]    stat_hits, stat_misses;
`endif

    l2_cache dut (
        .clk(clk), .reset(reset),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
        .l2_req_addr(l2_req_addr), .l2_req_rw(l2_req_rw), .l2_req_data(l2_req_data),
        .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef L2_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    int    cyc = 0, n_chk = 0, n_err = 0;
    int    resp_cnt = 0, mem_cnt = 0, last_resp_cyc = 0;
    mreq_t exp_mem[$];
    logic [LW-1:0] exp_resp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: every bus response and accepted memory request is popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (l2_resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                if (exp_resp.size() == 0) fail("unexpected_l2_resp");
                else chk("l2_resp_data", l2_resp_data, exp_resp.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                mem_cnt++;
                if (exp_mem.size() == 0) fail("unexpected_mem_req");
                else begin
                    mreq_t e;
                    e = exp_mem.pop_front();
                    chk("mem_req_addr", mem_req_addr, e.addr);
                    chk("mem_req_rw", mem_req_rw, e.rw);
                    if (e.rw) chk("mem_req_data", mem_req_data, e.data);
                end
            end
        end
    end

    task automatic push_mem(input logic [LAW-1:0] a, input logic rw, input logic [LW-1:0] d);
        mreq_t m;
        m.addr = a; m.rw = rw; m.data = d;
        exp_mem.push_back(m);
    endtask

    task automatic issue(input logic [LAW-1:0] a, input logic rw, input logic [LW-1:0] d,
                         output int hs);
        @(posedge clk); #1;
        l2_req_addr = a; l2_req_rw = rw; l2_req_data = d; l2_req_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge clk);
            if (l2_req_ready) hs = cyc;
        end
        if (hs < 0) fail("req_accept_timeout");
        @(posedge clk); #1;
        l2_req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int i = 0; i < 100 && c < 0; i++) begin
            @(negedge clk);
            if (l2_req_ready) c = cyc;
        end
        if (c < 0) fail("idle_timeout");
    endtask

    task automatic wait_fill_hs();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready && !mem_req_rw) seen = 1;
        end
        if (!seen) fail("fill_req_timeout");
        @(posedge clk); #1;
    endtask

    task automatic serve_fill(input logic [LW-1:0] d);
        wait_fill_hs();
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_data = d;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int hs, c, r, mc, rc;
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", l2_req_ready, 1);
        chk("rst_resp_valid", l2_resp_valid, 0);
        chk("rst_resp_data", l2_resp_data, 0);
        chk("rst_mem_ctl", {mem_req_valid, mem_req_rw}, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_mem_data", mem_req_data, 0);

        // Cold read miss, then a hit on the same line.
        push_mem(LAW'('h040), 1'b0, '0); exp_resp.push_back(PA);
        issue(LAW'('h040), 1'b0, '0, hs); serve_fill(PA); wait_idle(c);
        mc = mem_cnt;
        exp_resp.push_back(PA);
        issue(LAW'('h040), 1'b0, '0, hs); wait_idle(c);
        chk("rd_hit_latency", last_resp_cyc - hs, 2);
        chk("rd_hit_no_mem", mem_cnt, mc);

        // Write miss into clean set, then read it back.
        mc = mem_cnt; rc = resp_cnt;
        issue(LAW'('h041), 1'b1, P1, hs); wait_idle(c);
        chk("wr_miss_ready_lat", c - hs, 2);
        chk("wr_miss_no_mem", mem_cnt, mc);
        chk("wr_no_resp", resp_cnt, rc);
        exp_resp.push_back(P1);
        issue(LAW'('h041), 1'b0, '0, hs); wait_idle(c);
        chk("rd_hit2_latency", last_resp_cyc - hs, 2);
        chk("rd_hit2_no_mem", mem_cnt, mc);

        // Write 0x001 evicts dirty 0x041 while memory stalls.
        mem_req_ready = 1'b0;
        push_mem(LAW'('h041), 1'b1, P1);
        issue(LAW'('h001), 1'b1, P2, hs);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_valid) seen = 1;
        end
        if (!seen) fail("wb_req_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ctl", {mem_req_valid, mem_req_rw, l2_req_ready}, 3'b110);
            chk("stall_addr", mem_req_addr, LAW'('h041));
            chk("stall_data", mem_req_data, P1);
        end
        @(posedge clk); #1;
        r = cyc;
        mem_req_ready = 1'b1;
        wait_idle(c);
        chk("wb_release_lat", c - r, 1);

        // Read 0x041 now evicts dirty 0x001, then refills.
        rc = resp_cnt;
        push_mem(LAW'('h001), 1'b1, P2); push_mem(LAW'('h041), 1'b0, '0);
        exp_resp.push_back(P3);
        issue(LAW'('h041), 1'b0, '0, hs); serve_fill(P3); wait_idle(c);
        chk("evict_fill_resp_cnt", resp_cnt, rc + 1);

        // Reset in FILL_WAIT; a late memory response must be dropped.
        push_mem(LAW'('h080), 1'b0, '0);
        issue(LAW'('h080), 1'b0, '0, hs); wait_fill_hs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rc = resp_cnt;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_data = PA;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_drop_resp", resp_cnt, rc);
        chk("rst_drop_ready", {l2_req_ready, mem_req_valid}, 2'b10);
        mc = mem_cnt;
        push_mem(LAW'('h080), 1'b0, '0); exp_resp.push_back(P4);
        issue(LAW'('h080), 1'b0, '0, hs); serve_fill(P4); wait_idle(c);
        chk("rst_remiss_mem", mem_cnt, mc + 1);
        exp_resp.push_back(P4); exp_resp.push_back(P4);
        issue(LAW'('h080), 1'b0, '0, hs); wait_idle(c);
        issue(LAW'('h080), 1'b0, '0, hs); wait_idle(c);
`ifdef L2_STATS_EN
        chk("stat_misses", stat_misses, 1);
        chk("stat_hits", stat_hits, 2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("stat_rst", {stat_hits, stat_misses}, 0);
`endif
        repeat (2) @(negedge clk);
        chk("exp_resp_drained", exp_resp.size(), 0);
        chk("exp_mem_drained", exp_mem.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
